// File: rtl/ai_vector_core.sv
`default_nettype none
// ============================================================================
// Module   : ai_vector_core
// Brief    : LANES-wide signed vector core (bias-add, bias-add+ReLU, lane
//            accumulate) with valid/ready on both sides and a 2-stage pipe.
// Revision : 1.0  initial release
// ============================================================================
module ai_vector_core #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic [1:0]                  mode,
  input  logic [DATA_WIDTH-1:0]       bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        out_sat,
  output logic                        busy
);
  localparam logic [1:0] MODE_RELU = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;
  localparam int         EXT       = ACC_WIDTH - DATA_WIDTH;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{EXT{x[DATA_WIDTH-1]}}, x};
  endfunction

  // Returns {clipped flag, lane}; the value fits when all bits above the sign agree.
  function automatic logic [DATA_WIDTH:0] clip(input logic [ACC_WIDTH-1:0] v, input logic relu);
    logic [DATA_WIDTH-1:0] r;
    logic                  fits;
    fits = (&v[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|v[ACC_WIDTH-1:DATA_WIDTH-1]);
    if (fits)                r = v[DATA_WIDTH-1:0];
    else if (v[ACC_WIDTH-1]) r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                     r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    if (relu && r[DATA_WIDTH-1]) r = '0;
    return {!fits, r};
  endfunction

  state_t                      state_q, state_d;
  logic                        rdy_q;
  logic [1:0]                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0]       bias_q, bias_d;
  logic [LANES*ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                        s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_relu_q, s1_relu_d;
  logic [LANES*ACC_WIDTH-1:0]  s1_val_q, s1_val_d;
  logic                        s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_sat_q, s2_sat_d;
  logic [LANES*DATA_WIDTH-1:0] s2_data_q, s2_data_d;

  logic                        s1_advance, in_fire, produce, is_acc;
  logic [1:0]                  mode_eff;
  logic [DATA_WIDTH-1:0]       bias_eff;
  logic [LANES*ACC_WIDTH-1:0]  acc_sum, lane_res;
  logic [DATA_WIDTH:0]         clipped;

  // mode/bias come straight from the ports on a packet's first beat, else from the latch
  always_comb begin
    s1_advance = !s2_valid_q || out_ready;
    in_ready   = rdy_q && (!s1_valid_q || s1_advance);
    in_fire    = in_valid && in_ready;
    mode_eff   = (state_q == ST_IDLE) ? mode : mode_q;
    bias_eff   = (state_q == ST_IDLE) ? bias : bias_q;
    is_acc     = (mode_eff == MODE_ACC);
    produce    = in_fire && (!is_acc || in_last);
  end

  always_comb begin
    acc_sum  = '0;
    lane_res = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_sum[i*ACC_WIDTH +: ACC_WIDTH] =
        ((state_q == ST_IDLE) ? {ACC_WIDTH{1'b0}} : acc_q[i*ACC_WIDTH +: ACC_WIDTH])
        + sext(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
      lane_res[i*ACC_WIDTH +: ACC_WIDTH] = is_acc ? acc_sum[i*ACC_WIDTH +: ACC_WIDTH]
        : sext(in_data[i*DATA_WIDTH +: DATA_WIDTH]) + sext(bias_eff);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    if (in_fire) begin
      state_d = in_last ? ST_IDLE : ST_RUN;
      if (state_q == ST_IDLE) begin
        mode_d = mode;
        bias_d = bias;
      end
      if (is_acc) acc_d = in_last ? '0 : acc_sum;
    end
  end

  // Stage 1 holds the wide (unclipped) result; stage 2 clips and drives the outputs.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_relu_d  = s1_relu_q;
    s1_val_d   = s1_val_q;
    if (!s1_valid_q || s1_advance) begin
      s1_valid_d = produce;
      if (produce) begin
        s1_last_d = in_last;
        s1_relu_d = (mode_eff == MODE_RELU);
        s1_val_d  = lane_res;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_sat_d   = s2_sat_q;
    s2_data_d  = s2_data_q;
    clipped    = '0;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_last_d = s1_last_q;
        s2_sat_d  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          clipped = clip(s1_val_q[i*ACC_WIDTH +: ACC_WIDTH], s1_relu_q);
          s2_data_d[i*DATA_WIDTH +: DATA_WIDTH] = clipped[DATA_WIDTH-1:0];
          s2_sat_d = s2_sat_d | clipped[DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      mode_q     <= '0;
      bias_q     <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_val_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      mode_q     <= mode_d;
      bias_q     <= bias_d;
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_relu_q  <= s1_relu_d;
      s1_val_q   <= s1_val_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_sat_q   <= s2_sat_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_last_q;
  assign out_sat   = s2_sat_q;
  assign busy      = (state_q == ST_RUN) || s1_valid_q || s2_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ai_vector_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ai_vector_core
// Brief    : Self-checking bench for ai_vector_core: packet-level reference
//            model, scoreboard, directed literal checks and random traffic.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ai_vector_core;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int AW = 48;

  typedef struct {
    logic [LN*DW-1:0] d;
    logic             last;
    logic             sat;
    int               cyc;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LN*DW-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [DW-1:0]    bias = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LN*DW-1:0] out_data;
  logic             out_last;
  logic             out_sat;
  logic             busy;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  logic  rnd_rdy = 1'b0;
  logic  rdy_fixed = 1'b0;
  beat_t exp_q[$];
  beat_t got_q[$];

  // packet-level reference state
  logic       pkt_open = 1'b0;
  logic [1:0] pkt_mode = 2'd0;
  longint     pkt_bias = 0;
  longint     acc[LN];

  ai_vector_core #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mode(mode), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  function automatic logic [LN*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic longint lane(input logic [LN*DW-1:0] d, input int i);
    logic [DW-1:0] t;
    t = d[i*DW +: DW];
    return longint'($signed(t));
  endfunction

  function automatic longint wrap_acc(input longint v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return longint'($signed(t));
  endfunction

  task automatic ref_lane(input longint v, input logic relu, output logic [DW-1:0] r, output logic s);
    longint x;
    x = v;
    s = 1'b0;
    if (x > 64'sd2147483647) begin x = 64'sd2147483647; s = 1'b1; end
    else if (x < -64'sd2147483648) begin x = -64'sd2147483648; s = 1'b1; end
    if (relu && x < 0) x = 0;
    r = 32'(x);
  endtask

  task automatic model_beat(input logic [LN*DW-1:0] d, input logic last, input logic [1:0] md, input logic [DW-1:0] bs);
    beat_t         e;
    logic [DW-1:0] r;
    logic          s;
    if (!pkt_open) begin
      pkt_mode = md;
      pkt_bias = longint'($signed(bs));
      for (int i = 0; i < LN; i++) acc[i] = 0;
      pkt_open = 1'b1;
    end
    e.d = '0; e.sat = 1'b0; e.last = last; e.cyc = 0;
    if (pkt_mode == 2'd2) begin
      for (int i = 0; i < LN; i++) acc[i] = wrap_acc(acc[i] + lane(d, i));
      if (last) begin
        for (int i = 0; i < LN; i++) begin
          ref_lane(acc[i], 1'b0, r, s);
          e.d[i*DW +: DW] = r;
          e.sat = e.sat | s;
        end
        exp_q.push_back(e);
      end
    end else begin
      for (int i = 0; i < LN; i++) begin
        ref_lane(lane(d, i) + pkt_bias, pkt_mode == 2'd1, r, s);
        e.d[i*DW +: DW] = r;
        e.sat = e.sat | s;
      end
      exp_q.push_back(e);
    end
    if (last) pkt_open = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Presents one beat and holds it until accepted; pc is the cycle it was taken in.
  task automatic send(input logic [LN*DW-1:0] d, input logic last, input logic [1:0] md,
                      input logic [DW-1:0] bs, output int pc);
    int n;
    n = 0;
    pc = -1;
    in_data = d; in_last = last; mode = md; bias = bs; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) begin
      total++; bad++;
      $display("FAIL accept_timeout got=no_ready want=ready");
    end else begin
      pc = cyc;
      model_beat(d, last, md, bs);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {128'd0, 32'(exp_q.size())}, 160'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    rdy_fixed = v;
    @(posedge clk);
    #2;
  endtask

  // scoreboard and hold-during-stall checker
  initial begin
    beat_t            e;
    beat_t            g;
    logic             pst;
    logic [LN*DW-1:0] pd;
    logic             pl;
    logic             ps;
    pst = 1'b0; pd = '0; pl = 1'b0; ps = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pst = 1'b0;
      end else begin
        if (pst) chk("stall_hold", {29'd0, out_valid, out_last, out_sat, out_data}, {29'd0, 1'b1, pl, ps, pd});
        if (out_valid && out_ready) begin
          g.d = out_data; g.last = out_last; g.sat = out_sat; g.cyc = cyc;
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out got=%0h want=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_beat", {30'd0, out_last, out_sat, out_data}, {30'd0, e.last, e.sat, e.d});
          end
        end
        pst = out_valid && !out_ready;
        pd = out_data; pl = out_last; ps = out_sat;
      end
    end
  end

  initial begin
    int               pc0;
    int               pc1;
    int               nb;
    logic [LN*DW-1:0] rd;
    logic             lst;

    // reset state
    @(posedge clk);
    #2;
    chk("rst_outs", {124'd0, out_valid, out_last, out_sat, busy, out_data}, 160'd0);
    chk("rst_in_ready", {159'd0, in_ready}, 160'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    set_ready(1'b1);

    // ADD, two-beat packet
    got_q.delete();
    send(pack4(1, 2, 3, 4), 1'b0, 2'd0, 32'd1, pc0);
    send(pack4(-1, 0, 7, 9), 1'b1, 2'd0, 32'd1, pc1);
    drain();
    chk("add_count", {128'd0, 32'(got_q.size())}, {128'd0, 32'd2});
    if (got_q.size() == 2) begin
      chk("add_b0", {31'd0, got_q[0].last, got_q[0].d}, {31'd0, 1'b0, pack4(2, 3, 4, 5)});
      chk("add_b1", {31'd0, got_q[1].last, got_q[1].d}, {31'd0, 1'b1, pack4(0, 1, 8, 10)});
      chk("add_lat0", {128'd0, 32'(got_q[0].cyc - pc0)}, {128'd0, 32'd2});
      chk("add_lat1", {128'd0, 32'(got_q[1].cyc - pc1)}, {128'd0, 32'd2});
    end
    chk("idle_busy", {159'd0, busy}, 160'd0);

    // RELU with negative then positive bias
    got_q.delete();
    send(pack4(3, 10, -7, 32'h7FFFFFFF), 1'b1, 2'd1, -32'sd5, pc0);
    send(pack4(3, 10, -7, 32'h7FFFFFFF), 1'b1, 2'd1, 32'd5, pc1);
    drain();
    if (got_q.size() == 2) begin
      chk("relu_neg", {31'd0, got_q[0].sat, got_q[0].d}, {31'd0, 1'b0, pack4(0, 5, 0, 32'h7FFFFFFA)});
      chk("relu_pos", {31'd0, got_q[1].sat, got_q[1].d}, {31'd0, 1'b1, pack4(8, 15, 0, 32'h7FFFFFFF)});
    end else chk("relu_count", {128'd0, 32'(got_q.size())}, {128'd0, 32'd2});

    // ACC: saturating sum, then an in-range sum
    got_q.delete();
    for (int k = 0; k < 3; k++)
      send({4{32'h7FFFFFFF}}, k == 2, 2'd2, 32'd0, pc0);
    for (int k = 0; k < 3; k++)
      send(pack4(1, 2, 3, 4), k == 2, 2'd2, 32'd0, pc1);
    drain();
    if (got_q.size() == 2) begin
      chk("acc_sat", {30'd0, got_q[0].last, got_q[0].sat, got_q[0].d}, {30'd0, 1'b1, 1'b1, {4{32'h7FFFFFFF}}});
      chk("acc_sum", {30'd0, got_q[1].last, got_q[1].sat, got_q[1].d}, {30'd0, 1'b1, 1'b0, pack4(3, 6, 9, 12)});
      chk("acc_lat", {128'd0, 32'(got_q[1].cyc - pc1)}, {128'd0, 32'd2});
    end else chk("acc_count", {128'd0, 32'(got_q.size())}, {128'd0, 32'd2});

    // ACC latched while mode/bias toggle mid-packet; next packet takes a new mode
    got_q.delete();
    send(pack4(1, 2, 3, 4), 1'b0, 2'd2, 32'd0, pc0);
    send(pack4(1, 2, 3, 4), 1'b0, 2'd0, 32'd100, pc0);
    send(pack4(1, 2, 3, 4), 1'b0, 2'd1, -32'sd100, pc0);
    send(pack4(1, 2, 3, 4), 1'b1, 2'd3, 32'd7, pc0);
    send(pack4(5, 6, 7, 20), 1'b1, 2'd1, -32'sd10, pc0);
    drain();
    if (got_q.size() == 2) begin
      chk("latch_acc", {31'd0, got_q[0].last, got_q[0].d}, {31'd0, 1'b1, pack4(4, 8, 12, 16)});
      chk("next_relu", {31'd0, got_q[1].last, got_q[1].d}, {31'd0, 1'b1, pack4(0, 0, 0, 10)});
    end else chk("latch_count", {128'd0, 32'(got_q.size())}, {128'd0, 32'd2});

    // random traffic under random backpressure
    rnd_rdy = 1'b1;
    nb = 0;
    while (nb < 200) begin
      for (int i = 0; i < LN; i++) begin
        case ($urandom_range(0, 7))
          0: rd[i*DW +: DW] = 32'h7FFFFFFF;
          1: rd[i*DW +: DW] = 32'h80000000;
          2: rd[i*DW +: DW] = 32'($urandom_range(0, 40)) - 32'd20;
          default: rd[i*DW +: DW] = $urandom;
        endcase
      end
      lst = ($urandom_range(0, 4) == 0);
      send(rd, lst, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10, pc0);
      nb++;
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    if (pkt_open) send(pack4(1, 1, 1, 1), 1'b1, 2'd0, 32'd0, pc0);
    drain();
    rnd_rdy = 1'b0;

    // full-pipe stall, then reset mid-packet
    set_ready(1'b0);
    send(pack4(1, 1, 1, 1), 1'b0, 2'd0, 32'd0, pc0);
    send(pack4(2, 2, 2, 2), 1'b0, 2'd0, 32'd0, pc0);
    @(negedge clk);
    chk("full_stall", {157'd0, in_ready, out_valid, busy}, {157'd0, 1'b0, 1'b1, 1'b1});
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    pkt_open = 1'b0;
    chk("rst_async", {123'd0, in_ready, out_valid, out_last, out_sat, busy, out_data}, 160'd0);
    @(posedge clk);
    #1;
    chk("rst_edge", {123'd0, in_ready, out_valid, out_last, out_sat, busy, out_data}, 160'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", {158'd0, out_valid, busy}, 160'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
